// File: rtl/rob_core.sv
// 16-entry reorder buffer: in-order dispatch of up to 4 per cycle, out-of-order completion from
// 6 ports, in-order retirement of up to 4 consecutive completed entries with registered outputs.
module rob_core (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_ins_count,
  input  logic [56:0] i_ins_bundle0,
  input  logic [56:0] i_ins_bundle1,
  input  logic [56:0] i_ins_bundle2,
  input  logic [56:0] i_ins_bundle3,
  input  logic [5:0]  i_ins_old_p0,
  input  logic [5:0]  i_ins_old_p1,
  input  logic [5:0]  i_ins_old_p2,
  input  logic [5:0]  i_ins_old_p3,
  input  logic [5:0]  i_cmpl_en,
  input  logic [3:0]  i_cmpl0,
  input  logic [3:0]  i_cmpl1,
  input  logic [3:0]  i_cmpl2,
  input  logic [3:0]  i_cmpl3,
  input  logic [3:0]  i_cmpl4,
  input  logic [3:0]  i_cmpl5,
  output logic [3:0]  o_tail,
  output logic [4:0]  o_count,
  output logic        o_stall,
  output logic [2:0]  o_ret_count,
  output logic [5:0]  o_ret_old_p0,
  output logic [5:0]  o_ret_old_p1,
  output logic [5:0]  o_ret_old_p2,
  output logic [5:0]  o_ret_old_p3,
  output logic [56:0] o_ret_bundle0,
  output logic [56:0] o_ret_bundle1,
  output logic [56:0] o_ret_bundle2,
  output logic [56:0] o_ret_bundle3
);

  localparam int Depth = 16;
  localparam int Width = 4;
  localparam int Cmpl  = 6;

  logic [56:0] ins_bundle [Width];
  logic [5:0]  ins_old_p  [Width];
  logic [3:0]  cmpl_idx   [Cmpl];

  assign ins_bundle[0] = i_ins_bundle0;
  assign ins_bundle[1] = i_ins_bundle1;
  assign ins_bundle[2] = i_ins_bundle2;
  assign ins_bundle[3] = i_ins_bundle3;
  assign ins_old_p[0]  = i_ins_old_p0;
  assign ins_old_p[1]  = i_ins_old_p1;
  assign ins_old_p[2]  = i_ins_old_p2;
  assign ins_old_p[3]  = i_ins_old_p3;
  assign cmpl_idx[0]   = i_cmpl0;
  assign cmpl_idx[1]   = i_cmpl1;
  assign cmpl_idx[2]   = i_cmpl2;
  assign cmpl_idx[3]   = i_cmpl3;
  assign cmpl_idx[4]   = i_cmpl4;
  assign cmpl_idx[5]   = i_cmpl5;

  logic [Depth-1:0] done_q, done_d;
  logic [5:0]       old_p_q  [Depth];
  logic [56:0]      bundle_q [Depth];
  logic [3:0]       head_q, head_d;
  logic [3:0]       tail_q, tail_d;
  logic [4:0]       count_q, count_d;

  logic [2:0]       ret_count_q, ret_count_d;
  logic [5:0]       ret_old_p_q  [Width];
  logic [5:0]       ret_old_p_d  [Width];
  logic [56:0]      ret_bundle_q [Width];
  logic [56:0]      ret_bundle_d [Width];

  logic [2:0]       alloc_n;
  logic [2:0]       ret_n;
  logic             accept;
  logic             ret_stop;

  assign o_tail  = tail_q;
  assign o_count = count_q;
  // Stall uses the raw request against current occupancy, ignoring same-cycle retirement.
  assign o_stall = ({2'b00, i_ins_count} > (5'd16 - count_q));

  assign accept  = (i_ins_count != 3'd0) && (i_ins_count <= 3'd4) && !o_stall;
  assign alloc_n = accept ? i_ins_count : 3'd0;

  always_comb begin
    ret_n    = 3'd0;
    ret_stop = 1'b0;
    for (int j = 0; j < Width; j++) begin
      if (!ret_stop && (5'(j) < count_q) && done_q[head_q + 4'(j)]) begin
        ret_n = ret_n + 3'd1;
      end else begin
        ret_stop = 1'b1;
      end
    end
  end

  always_comb begin
    done_d = done_q;
    for (int k = 0; k < Cmpl; k++) begin
      if (i_cmpl_en[k]) done_d[cmpl_idx[k]] = 1'b1;
    end
    // Allocation applied last so it overrides a same-cycle completion of the same index.
    for (int i = 0; i < Width; i++) begin
      if (3'(i) < alloc_n) done_d[tail_q + 4'(i)] = 1'b0;
    end
    head_d      = head_q + 4'(ret_n);
    tail_d      = tail_q + 4'(alloc_n);
    count_d     = count_q + 5'(alloc_n) - 5'(ret_n);
    ret_count_d = ret_n;
    for (int j = 0; j < Width; j++) begin
      ret_old_p_d[j]  = '0;
      ret_bundle_d[j] = '0;
      if (3'(j) < ret_n) begin
        ret_old_p_d[j]  = old_p_q[head_q + 4'(j)];
        ret_bundle_d[j] = bundle_q[head_q + 4'(j)];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ret_count_q <= '0;
      for (int j = 0; j < Width; j++) begin
        ret_old_p_q[j]  <= '0;
        ret_bundle_q[j] <= '0;
      end
    end else begin
      done_q      <= done_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ret_count_q <= ret_count_d;
      for (int j = 0; j < Width; j++) begin
        ret_old_p_q[j]  <= ret_old_p_d[j];
        ret_bundle_q[j] <= ret_bundle_d[j];
      end
    end
  end

  // Payload storage needs no reset; only occupied entries are ever read.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < Width; i++) begin
      if (3'(i) < alloc_n) begin
        old_p_q[tail_q + 4'(i)]  <= ins_old_p[i];
        bundle_q[tail_q + 4'(i)] <= ins_bundle[i];
      end
    end
  end

  assign o_ret_count   = ret_count_q;
  assign o_ret_old_p0  = ret_old_p_q[0];
  assign o_ret_old_p1  = ret_old_p_q[1];
  assign o_ret_old_p2  = ret_old_p_q[2];
  assign o_ret_old_p3  = ret_old_p_q[3];
  assign o_ret_bundle0 = ret_bundle_q[0];
  assign o_ret_bundle1 = ret_bundle_q[1];
  assign o_ret_bundle2 = ret_bundle_q[2];
  assign o_ret_bundle3 = ret_bundle_q[3];

endmodule

// File: tb/tb_rob_core.sv
// Randomized scoreboard bench for rob_core: a program-order queue model predicts occupancy,
// stall, tail and the registered retire bundle for every edge.
module tb_rob_core;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [2:0]  ins_count = '0;
  logic [56:0] ins_bundle [4];
  logic [5:0]  ins_old_p  [4];
  logic [5:0]  cmpl_en = '0;
  logic [3:0]  cmpl [6];
  logic [3:0]  o_tail;
  logic [4:0]  o_count;
  logic        o_stall;
  logic [2:0]  o_ret_count;
  logic [5:0]  ret_old_p [4];
  logic [56:0] ret_bundle [4];

  always #5 i_clk = ~i_clk;

  rob_core dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ins_count   (ins_count),
    .i_ins_bundle0 (ins_bundle[0]),
    .i_ins_bundle1 (ins_bundle[1]),
    .i_ins_bundle2 (ins_bundle[2]),
    .i_ins_bundle3 (ins_bundle[3]),
    .i_ins_old_p0  (ins_old_p[0]),
    .i_ins_old_p1  (ins_old_p[1]),
    .i_ins_old_p2  (ins_old_p[2]),
    .i_ins_old_p3  (ins_old_p[3]),
    .i_cmpl_en     (cmpl_en),
    .i_cmpl0       (cmpl[0]),
    .i_cmpl1       (cmpl[1]),
    .i_cmpl2       (cmpl[2]),
    .i_cmpl3       (cmpl[3]),
    .i_cmpl4       (cmpl[4]),
    .i_cmpl5       (cmpl[5]),
    .o_tail        (o_tail),
    .o_count       (o_count),
    .o_stall       (o_stall),
    .o_ret_count   (o_ret_count),
    .o_ret_old_p0  (ret_old_p[0]),
    .o_ret_old_p1  (ret_old_p[1]),
    .o_ret_old_p2  (ret_old_p[2]),
    .o_ret_old_p3  (ret_old_p[3]),
    .o_ret_bundle0 (ret_bundle[0]),
    .o_ret_bundle1 (ret_bundle[1]),
    .o_ret_bundle2 (ret_bundle[2]),
    .o_ret_bundle3 (ret_bundle[3])
  );

  typedef struct {
    int          idx;
    logic [5:0]  old_p;
    logic [56:0] bundle;
    bit          done;
  } entry_t;

  typedef struct packed {
    logic [2:0]        n;
    logic [3:0][5:0]   op;
    logic [3:0][56:0]  b;
  } sb_t;

  entry_t mq[$];
  sb_t    expq[$];
  int     m_tail = 0;
  int     n_checks = 0;
  int     n_pass = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: each registered retire output is compared with the oldest prediction.
  always @(negedge i_clk) begin
    if (expq.size() > 0) begin
      sb_t s;
      s = expq.pop_front();
      chk("ret_count", 64'(o_ret_count), 64'(s.n));
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("ret_old_p%0d", j), 64'(ret_old_p[j]), 64'(s.op[j]));
        chk($sformatf("ret_bundle%0d", j), 64'(ret_bundle[j]), 64'(s.b[j]));
      end
    end
  end

  task automatic clr_in();
    ins_count = '0;
    cmpl_en   = '0;
    for (int k = 0; k < 6; k++) cmpl[k] = '0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 4; i++) begin
      ins_old_p[i]  = 6'($urandom);
      ins_bundle[i] = {25'($urandom), $urandom};
    end
  endtask

  function automatic int head_idx();
    return (m_tail - mq.size() + 16) % 16;
  endfunction

  // Check combinational outputs, advance the model one edge, then clock the DUT.
  task automatic step();
    int  cnt;
    bit  stall_e, acc;
    int  n;
    sb_t s;
    #1;
    cnt     = int'(ins_count);
    stall_e = cnt > (16 - mq.size());
    acc     = (cnt >= 1) && (cnt <= 4) && !stall_e;
    chk("stall", 64'(o_stall), 64'(stall_e));
    chk("tail", 64'(o_tail), 64'(m_tail));
    chk("count", 64'(o_count), 64'(mq.size()));
    n = 0;
    while (n < 4 && n < mq.size() && mq[n].done) n++;
    s = '0;
    s.n = 3'(n);
    for (int j = 0; j < n; j++) begin
      s.op[j] = mq[j].old_p;
      s.b[j]  = mq[j].bundle;
    end
    expq.push_back(s);
    for (int k = 0; k < 6; k++) begin
      if (cmpl_en[k]) begin
        foreach (mq[e]) if (mq[e].idx == int'(cmpl[k])) mq[e].done = 1'b1;
      end
    end
    for (int j = 0; j < n; j++) void'(mq.pop_front());
    if (acc) begin
      for (int i = 0; i < cnt; i++) begin
        entry_t e;
        e.idx = (m_tail + i) % 16;
        e.old_p = ins_old_p[i];
        e.bundle = ins_bundle[i];
        e.done = 1'b0;
        mq.push_back(e);
      end
      m_tail = (m_tail + cnt) % 16;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    sb_t s;
    #2;
    clr_in();
    i_rst = 1'b1;
    #1;
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_ret_count", 64'(o_ret_count), 64'd0);
    chk("rst_tail", 64'(o_tail), 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    mq.delete();
    expq.delete();
    m_tail = 0;
    s = '0;
    expq.push_back(s);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic disp(int cnt);
    clr_in();
    rand_payload();
    ins_count = 3'(cnt);
    step();
  endtask

  task automatic complete_range(int first, int num);
    clr_in();
    for (int k = 0; k < num; k++) begin
      cmpl_en[k] = 1'b1;
      cmpl[k]    = 4'((first + k) % 16);
    end
    step();
  endtask

  task automatic idle(int cycles);
    clr_in();
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    int t;
    clr_in();
    rand_payload();
    @(negedge i_clk);
    do_reset();

    // Dispatch 3 with old_p 5,6,7, then out-of-order completion.
    clr_in();
    rand_payload();
    ins_old_p[0] = 6'd5; ins_old_p[1] = 6'd6; ins_old_p[2] = 6'd7;
    ins_count = 3'd3;
    step();
    idle(1);
    clr_in(); cmpl_en = 6'b000011; cmpl[0] = 4'd1; cmpl[1] = 4'd2;
    step();
    idle(1);
    complete_range(0, 1);
    idle(2);

    // Completions in the same cycle as dispatch are overridden.
    clr_in();
    rand_payload();
    ins_count = 3'd3;
    cmpl_en = 6'b000111;
    cmpl[0] = 4'(m_tail); cmpl[1] = 4'((m_tail + 2) % 16); cmpl[2] = 4'((m_tail + 1) % 16);
    step();
    idle(2);
    complete_range(head_idx(), 3);
    idle(2);

    // Fill to 16, stall, retire one, then accept one.
    for (int i = 0; i < 4; i++) disp(4);
    disp(1);
    complete_range(head_idx(), 1);
    idle(1);
    disp(1);
    for (int i = 0; i < 4; i++) complete_range((head_idx() + 4 * i) % 16, 4);
    idle(6);

    // Wrap: head at 14 with 14,15,0,1 done together.
    do_reset();
    disp(4); disp(4); disp(4); disp(2);
    complete_range(0, 6); complete_range(6, 6); complete_range(12, 2);
    idle(5);
    disp(4);
    complete_range(14, 4);
    idle(2);

    // Reset with 8 live entries, then first dispatch lands at index 0.
    disp(4); disp(4);
    do_reset();
    disp(2);
    idle(1);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      clr_in();
      rand_payload();
      if (mq.size() <= 9 && $urandom_range(0, 15) == 0) ins_count = 3'($urandom_range(5, 7));
      else ins_count = 3'($urandom_range(0, 4));
      cmpl_en = 6'($urandom);
      for (int k = 0; k < 6; k++) begin
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          cmpl[k] = 4'(mq[$urandom_range(0, mq.size() - 1)].idx);
        else
          cmpl[k] = 4'($urandom);
      end
      step();
    end
    idle(3);

    t = 0;
    while (expq.size() > 0 && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
